// File: rtl/riscv_data_mem_responder.sv
// Data-port responder for the RI5CY core: word RAM at BASE_ADDR with byte-enable
// writes, programmable grant wait states and a single-cycle rvalid response.
module riscv_data_mem_responder #(
  parameter int unsigned            ADDR_WIDTH  = 32,
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            MEM_WORDS   = 4096,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR   = 32'h0010_0000,
  parameter int unsigned            WAIT_STATES = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    data_req_i,
  output logic                    data_gnt_o,
  output logic                    data_rvalid_o,
  input  logic                    data_we_i,
  input  logic [DATA_WIDTH/8-1:0] data_be_i,
  input  logic [ADDR_WIDTH-1:0]   data_addr_i,
  input  logic [DATA_WIDTH-1:0]   data_wdata_i,
  output logic [DATA_WIDTH-1:0]   data_rdata_o,
  output logic                    data_err_o
);

  localparam int unsigned         BE_W       = DATA_WIDTH / 8;
  localparam int unsigned         IDX_W      = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * MEM_WORDS);
  localparam logic [3:0]          WS         = 4'(WAIT_STATES);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              wcnt_q, wcnt_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic                    rd_hit_q, rd_hit_d;
  logic [DATA_WIDTH-1:0]   ram_rdata_q;
  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];

  logic                    gnt;
  logic                    hit;
  logic                    wr_en;
  logic                    rd_en;
  logic [IDX_W-1:0]        idx;

  // Low index bits of (addr - BASE_ADDR) only depend on the low address bits.
  assign hit   = ({1'b0, data_addr_i} >= {1'b0, BASE_ADDR}) && ({1'b0, data_addr_i} < ADDR_LIMIT);
  assign idx   = data_addr_i[IDX_W+1:2] - BASE_ADDR[IDX_W+1:2];
  assign gnt   = data_req_i & ~rst_i & (wcnt_q == WS);
  assign wr_en = gnt & hit & data_we_i;
  assign rd_en = gnt & hit & ~data_we_i;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    rvalid_d = gnt;
    err_d    = gnt ? ~hit : err_q;
    rd_hit_d = gnt ? (hit & ~data_we_i) : rd_hit_q;
    case (state_q)
      ST_IDLE: begin
        if (data_req_i && !gnt) begin
          wcnt_d  = wcnt_q + 4'd1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!data_req_i || gnt) begin
          wcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          wcnt_d  = wcnt_q + 4'd1;
        end
      end
      default: begin
        wcnt_d  = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      wcnt_q   <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rd_hit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rd_hit_q <= rd_hit_d;
    end
  end

  // NOTE: the RAM and its read register have no reset so they map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (data_be_i[b]) mem[idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
      end
    end
    if (rd_en) ram_rdata_q <= mem[idx];
  end

  // A response pending when reset arrives is suppressed in that same cycle.
  assign data_gnt_o    = gnt;
  assign data_rvalid_o = rvalid_q & ~rst_i;
  assign data_rdata_o  = rd_hit_q ? ram_rdata_q : '0;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_riscv_data_mem_responder.sv
// Randomized and directed bench for riscv_data_mem_responder: a WAIT_STATES=0
// instance against a transaction-level model, and a WAIT_STATES=3 instance for stalls.
module tb_riscv_data_mem_responder;

  localparam logic [31:0] BASE  = 32'h0010_0000;
  localparam logic [31:0] LIMIT = 32'h0010_4000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Instance with no wait states
  logic        rst0 = 1'b1, req0 = 1'b0, we0 = 1'b0;
  logic [3:0]  be0 = 4'h0;
  logic [31:0] addr0 = '0, wdata0 = '0;
  logic        gnt0, rvalid0, err0;
  logic [31:0] rdata0;

  // Instance with three wait states
  logic        rst3 = 1'b1, req3 = 1'b0, we3 = 1'b0;
  logic [3:0]  be3 = 4'h0;
  logic [31:0] addr3 = '0, wdata3 = '0;
  logic        gnt3, rvalid3, err3;
  logic [31:0] rdata3;

  riscv_data_mem_responder #(.WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst0), .data_req_i(req0), .data_gnt_o(gnt0),
    .data_rvalid_o(rvalid0), .data_we_i(we0), .data_be_i(be0),
    .data_addr_i(addr0), .data_wdata_i(wdata0), .data_rdata_o(rdata0),
    .data_err_o(err0)
  );

  riscv_data_mem_responder #(.WAIT_STATES(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .data_req_i(req3), .data_gnt_o(gnt3),
    .data_rvalid_o(rvalid3), .data_we_i(we3), .data_be_i(be3),
    .data_addr_i(addr3), .data_wdata_i(wdata3), .data_rdata_o(rdata3),
    .data_err_o(err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: word memory plus the one response owed for the last grant.
  logic [31:0] mem_m [int unsigned];
  logic        rsp_pend   = 1'b0;
  logic [31:0] rsp_rdata  = '0;
  logic        rsp_err    = 1'b0;
  logic [31:0] last_rdata = '0;
  logic        last_err   = 1'b0;

  task automatic model_access(input logic we, input logic [3:0] be,
                              input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned idx;
    logic [31:0] w;
    rsp_pend = 1'b1;
    if (addr < BASE || addr >= LIMIT) begin
      rsp_rdata = '0;
      rsp_err   = 1'b1;
    end else begin
      idx     = (addr - BASE) >> 2;
      rsp_err = 1'b0;
      if (we) begin
        w = mem_m.exists(idx) ? mem_m[idx] : '0;
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        mem_m[idx] = w;
        rsp_rdata  = '0;
      end else begin
        rsp_rdata  = mem_m[idx];
      end
    end
  endtask

  // One clock cycle on the zero-wait instance: drive, check mid-cycle, advance model.
  task automatic cycle0(input logic rst, input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    @(posedge clk); #1;
    rst0 = rst; req0 = req; we0 = we; be0 = be; addr0 = addr; wdata0 = wdata;
    @(negedge clk);
    check("gnt", gnt0, req & ~rst);
    if (rst) begin
      check("rvalid_in_reset", rvalid0, 1'b0);
    end else if (rsp_pend) begin
      check("rvalid", rvalid0, 1'b1);
      check("rdata", rdata0, rsp_rdata);
      check("err", err0, rsp_err);
      last_rdata = rsp_rdata;
      last_err   = rsp_err;
    end else begin
      check("rvalid_idle", rvalid0, 1'b0);
      check("rdata_hold", rdata0, last_rdata);
      check("err_hold", err0, last_err);
    end
    if (rst) begin
      rsp_pend   = 1'b0;
      last_rdata = '0;
      last_err   = 1'b0;
    end else if (req) begin
      model_access(we, be, addr, wdata);
    end else begin
      rsp_pend = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    if (r == 0) begin
      case ($urandom_range(0, 4))
        0:       a = 32'h0000_0000;
        1:       a = BASE - 32'd4;
        2:       a = LIMIT;
        3:       a = 32'hFFFF_FFFC;
        default: a = $urandom() | 32'h8000_0000;
      endcase
      a[1:0] = 2'($urandom_range(0, 3));
    end else if (r == 1) begin
      a = BASE + 32'd4095 * 4 + 32'($urandom_range(0, 3));
    end else begin
      a = BASE + 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(0, 3));
    end
    return a;
  endfunction

  // Holds one request on the three-wait instance and checks its stall and response.
  task automatic txn3(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    int   n;
    logic seen;
    n = 0;
    seen = 1'b0;
    @(posedge clk); #1;
    req3 = 1'b1; we3 = we; be3 = 4'hF; addr3 = addr; wdata3 = wdata;
    while (!seen && n < 20) begin
      @(negedge clk);
      if (gnt3) begin
        seen = 1'b1;
      end else begin
        check({tag, "_rvalid_wait"}, rvalid3, 1'b0);
        n++;
        @(posedge clk); #1;
      end
    end
    check({tag, "_gnt_cycle"}, n, 3);
    @(posedge clk); #1;
    req3 = 1'b0;
    @(negedge clk);
    check({tag, "_rvalid"}, rvalid3, 1'b1);
    check({tag, "_rdata"}, rdata3, exp_rdata);
    check({tag, "_err"}, err3, exp_err);
    check({tag, "_gnt_after"}, gnt3, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_rvalid_once"}, rvalid3, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a request present: no grant, no response, outputs cleared.
    cycle0(1'b1, 1'b1, 1'b0, 4'hF, BASE, '0);
    cycle0(1'b1, 1'b1, 1'b0, 4'hF, BASE, '0);
    cycle0(1'b0, 1'b0, 1'b0, 4'h0, '0, '0);

    // Full-word write then read of the same word.
    cycle0(1'b0, 1'b1, 1'b1, 4'hF, 32'h0010_0010, 32'hDEAD_BEEF);
    cycle0(1'b0, 1'b1, 1'b0, 4'hF, 32'h0010_0010, '0);
    cycle0(1'b0, 1'b0, 1'b0, 4'h0, '0, '0);

    // Preload the working set, including the last word of the RAM.
    for (int i = 0; i < 16; i++) begin
      if (i != 4) cycle0(1'b0, 1'b1, 1'b1, 4'hF, BASE + 32'(i) * 4, $urandom());
    end
    cycle0(1'b0, 1'b1, 1'b1, 4'hF, BASE + 32'd4095 * 4, 32'h0BAD_F00D);

    // Back-to-back reads of words 0..3 with req held.
    for (int i = 0; i < 4; i++) cycle0(1'b0, 1'b1, 1'b0, 4'hF, BASE + 32'(i) * 4, '0);
    cycle0(1'b0, 1'b0, 1'b0, 4'h0, '0, '0);

    // Partial write merges with existing bytes.
    cycle0(1'b0, 1'b1, 1'b1, 4'hF, BASE + 32'h14, 32'hAABB_CCDD);
    cycle0(1'b0, 1'b1, 1'b1, 4'b0101, BASE + 32'h14, 32'h1122_3344);
    cycle0(1'b0, 1'b1, 1'b0, 4'h0, BASE + 32'h14, '0);
    cycle0(1'b0, 1'b0, 1'b0, 4'h0, '0, '0);
    check("be_merge_word", mem_m[5], 32'hAA22_CC44);

    // Out-of-range accesses and both range boundaries.
    cycle0(1'b0, 1'b1, 1'b0, 4'hF, 32'h0000_0000, '0);
    cycle0(1'b0, 1'b1, 1'b1, 4'hF, 32'h0010_4000, 32'h5555_5555);
    cycle0(1'b0, 1'b1, 1'b0, 4'hF, 32'h000F_FFFC, '0);
    cycle0(1'b0, 1'b1, 1'b0, 4'hF, 32'h0010_3FFC, '0);
    cycle0(1'b0, 1'b1, 1'b0, 4'hF, 32'h0010_0000, '0);
    cycle0(1'b0, 1'b1, 1'b1, 4'h0, BASE + 32'h8, 32'hFFFF_FFFF);
    cycle0(1'b0, 1'b1, 1'b0, 4'hF, BASE + 32'h8, '0);
    cycle0(1'b0, 1'b0, 1'b0, 4'h0, '0, '0);

    // Reset in the cycle after a read grant drops the response but keeps RAM.
    cycle0(1'b0, 1'b1, 1'b0, 4'hF, BASE + 32'h14, '0);
    cycle0(1'b1, 1'b0, 1'b0, 4'h0, '0, '0);
    cycle0(1'b0, 1'b1, 1'b0, 4'hF, BASE + 32'h14, '0);
    cycle0(1'b0, 1'b0, 1'b0, 4'h0, '0, '0);

    // Random traffic over the working set, misses and occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle0(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             4'($urandom_range(0, 15)), rand_addr(), $urandom());
    end
    cycle0(1'b0, 1'b0, 1'b0, 4'h0, '0, '0);

    // Wait-state instance: release reset, then stalled write/read/miss traffic.
    @(posedge clk); #1;
    rst3 = 1'b0;
    @(negedge clk);
    check("ws3_reset_rvalid", rvalid3, 1'b0);
    check("ws3_reset_rdata", rdata3, '0);
    txn3("ws3_write", 1'b1, BASE + 32'h20, 32'hCAFE_F00D, '0, 1'b0);
    txn3("ws3_read", 1'b0, BASE + 32'h20, '0, 32'hCAFE_F00D, 1'b0);
    txn3("ws3_miss", 1'b0, 32'h0000_0000, '0, '0, 1'b1);

    // Request withdrawn before grant: no grant, no response, counter restarts.
    @(posedge clk); #1;
    req3 = 1'b1; we3 = 1'b0; addr3 = BASE + 32'h20;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("ws3_abort_gnt", gnt3, 1'b0);
      @(posedge clk); #1;
    end
    req3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ws3_abort_gnt_idle", gnt3, 1'b0);
      check("ws3_abort_rvalid", rvalid3, 1'b0);
      @(posedge clk); #1;
    end
    txn3("ws3_reread", 1'b0, BASE + 32'h20, '0, 32'hCAFE_F00D, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/riscv_data_mem_responder.md
Name: riscv_data_mem_responder

Overview:
- Responder (slave) end of the RI5CY core data memory interface (req/gnt/rvalid, we/be/addr/wdata/rdata/err).
- Backs a word-addressed on-chip data RAM mapped at a fixed base address; out-of-range accesses get an error response.
- Sits directly on the core's data port in the MCU top ahead of the AXI interconnect bring-up, and later as the local data scratchpad.
- Programmable grant wait states to exercise the core's stall paths.

Parameters:
- ADDR_WIDTH, 32, width of data_addr_i.
- DATA_WIDTH, 32, data word width; must be 32 (byte enables = DATA_WIDTH/8).
- MEM_WORDS, 4096, RAM depth in words; power of two, >= 2.
- BASE_ADDR, 32'h0010_0000, byte address of word 0; aligned to 4*MEM_WORDS.
- WAIT_STATES, 0, cycles req must be held before gnt; range 0..15.

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- data_req_i  in  1  request valid from core
- data_gnt_o  out  1  request accepted this cycle
- data_rvalid_o  out  1  response valid, one pulse per granted request
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  DATA_WIDTH/8  byte enables
- data_addr_i  in  ADDR_WIDTH  byte address, bits [1:0] ignored
- data_wdata_i  in  DATA_WIDTH  write data
- data_rdata_o  out  DATA_WIDTH  read data, valid with rvalid
- data_err_o  out  1  error flag, valid with rvalid

Behaviour:
- Reset (rst_i=1 at edge): data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0, wait counter=0, pending response dropped. RAM contents not cleared.
- Handshake: core holds req/we/be/addr/wdata stable until gnt. Transfer occurs in the cycle req=1 and gnt=1.
- Grant is combinational from req and the wait counter: gnt = req & (wcnt == WAIT_STATES).
- FSM IDLE/WAIT:
  - IDLE: req=1 with WAIT_STATES=0 grants immediately and stays IDLE; otherwise wcnt increments and the FSM enters WAIT.
  - WAIT: wcnt increments while req=1. Grant is issued when wcnt==WAIT_STATES, then wcnt returns to 0 and the FSM to IDLE.
  - req dropping before gnt is a protocol violation: wcnt clears, return to IDLE, no response.
- Response latency: data_rvalid_o=1 exactly one cycle after each gnt, and for one cycle only. At most one response outstanding.
- With WAIT_STATES=0, back-to-back grants are allowed (one per cycle); rvalid for request N coincides with gnt for request N+1.
- Decode:
  - hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR + 4*MEM_WORDS).
  - Index = (addr - BASE_ADDR)[clog2(MEM_WORDS)+1:2].
- Write hit: at the gnt edge, byte i of RAM[index] is updated iff be[i]=1. be=0 gives no change and no error. Response has rdata=0, err=0.
- Read hit: RAM[index] is read synchronously at the gnt edge and presented with rvalid. be is ignored and the full word is returned.
- Miss (read or write): no RAM access, response has rdata=0, err=1.
- Read-after-write to the same word in consecutive grants returns the newly written bytes (the write commits at edge N, the read samples at edge N+1).
- data_rdata_o and data_err_o hold their last values while rvalid=0; only sampled when rvalid=1.
- Reset asserted while a response is pending: that response is never issued. A write granted in the same cycle that reset is sampled is not committed.
- Implementation: single-port inferable RAM (Cyclone V M10K), byte-enable write.

Test Plan:
- WAIT_STATES=0: write 0xDEADBEEF to 0x0010_0010 with be=4'hF, then read 0x0010_0010 -> gnt same cycle as req both times; rvalid next cycle; read rdata=0xDEADBEEF, err=0.
- Byte enables: write 0x11223344 with be=4'b0101 over a word holding 0xAABBCCDD -> a subsequent read returns 0xAA22CC44.
- Back-to-back: 4 consecutive reads of 0x0010_0000..0x0010_000C with req held high -> 4 gnts in 4 cycles; rvalid high for 4 consecutive cycles starting 1 cycle after the first gnt; data matches preload.
- WAIT_STATES=3: read held from cycle 0 -> gnt in cycle 3 only; rvalid in cycle 4; no gnt in cycles 0-2.
- Out of range: read 0x0000_0000 and write 0x0010_4000 (MEM_WORDS=4096) -> rvalid with err=1 and rdata=0; a later read of 0x0010_0000 shows no corruption.
- Reset mid-op: rst_i=1 in the cycle after gnt of a read -> rvalid stays 0 and gnt=0 during reset; after release, an immediate read returns data preserved from before reset.
